keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 177 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column per scan tick,
// debounces press and release of the captured row, and reports the key code.
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV       = 16'd50000,
    parameter logic [3:0]  DEBOUNCE_TICKS = 4'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned LINE_W = 4;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t              state;
    logic [LINE_W-1:0]   sync_meta;
    logic [LINE_W-1:0]   row_sync;
    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    col_idx;
    logic [IDX_W-1:0]    cap_row;
    logic [CNT_W-1:0]    dcnt;

    logic                tick_c;
    logic                any_low_c;
    logic [IDX_W-1:0]    low_row_c;
    logic                cap_low_c;
    logic [CNT_W-1:0]    dcnt_inc_c;
    logic [IDX_W-1:0]    col_next_c;
    logic [LINE_W-1:0]   cols_next_c;

    // Hex code printed on the key at row r, column c.
    function automatic logic [3:0] key_code(input logic [IDX_W-1:0] r,
                                            input logic [IDX_W-1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchronizer; idle (pulled-up) lines read as ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 4'b1111;
            row_sync  <= 4'b1111;
        end else begin
            sync_meta <= rows;
            row_sync  <= sync_meta;
        end
    end

    // Free-running scan divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick_c      = (div_cnt == SCAN_DIV - DIV_W'(1));
    assign any_low_c   = ~(&row_sync);
    assign cap_low_c   = ~row_sync[cap_row];
    assign dcnt_inc_c  = dcnt + CNT_W'(1);
    assign col_next_c  = col_idx + IDX_W'(1);
    assign cols_next_c = ~(LINE_W'(1) << col_next_c);

    // Lowest-index low row wins when several are active.
    always_comb begin
        low_row_c = 2'd0;
        if (!row_sync[0]) begin
            low_row_c = 2'd0;
        end else if (!row_sync[1]) begin
            low_row_c = 2'd1;
        end else if (!row_sync[2]) begin
            low_row_c = 2'd2;
        end else if (!row_sync[3]) begin
            low_row_c = 2'd3;
        end
    end

    // Scan/debounce FSM; everything but key_valid advances only on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= '0;
            cols      <= 4'b1110;
            cap_row   <= '0;
            dcnt      <= '0;
            key       <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (tick_c) begin
                case (state)
                    SCAN: begin
                        if (any_low_c) begin
                            cap_row <= low_row_c;
                            dcnt    <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            col_idx <= col_next_c;
                            cols    <= cols_next_c;
                        end
                    end
                    DEBOUNCE: begin
                        if (cap_low_c) begin
                            dcnt <= dcnt_inc_c;
                            if (dcnt_inc_c == DEBOUNCE_TICKS) begin
                                state     <= HELD;
                                key       <= key_code(cap_row, col_idx);
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end
                        end else begin
                            dcnt  <= '0;
                            state <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!cap_low_c) begin
                            dcnt  <= '0;
                            state <= RELEASE;
                        end
                    end
                    RELEASE: begin
                        if (!cap_low_c) begin
                            dcnt <= dcnt_inc_c;
                            if (dcnt_inc_c == DEBOUNCE_TICKS) begin
                                state    <= SCAN;
                                key_held <= 1'b0;
                                col_idx  <= col_next_c;
                                cols     <= cols_next_c;
                            end
                        end else begin
                            dcnt  <= '0;
                            state <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a physical keypad model drives rows from cols,
// expected key codes are queued from press timing and checked on each pulse.
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int unsigned SD   = 4;
    localparam int unsigned DT   = 3;
    localparam int unsigned LONG = 60;
    localparam int unsigned GAP  = (DT + 4) * SD;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [3:0]  key;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed = 16'h0;
    logic [3:0]  exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    keypad_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE_TICKS(4'd3)) dut (
        .clk       (clk),
        .reset     (reset),
        .rows      (rows),
        .cols      (cols),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // A pressed switch shorts its row to its column when that column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
    end

    // Key legend straight from the keypad layout, one 16-bit string per row.
    function automatic logic [3:0] key_of(input int r, input int c);
        logic [15:0] rc;
        case (r)
            0: rc = 16'h123A;
            1: rc = 16'h456B;
            2: rc = 16'h789C;
            default: rc = 16'hE0FD;
        endcase
        rc = rc >> (4 * (3 - c));
        return rc[3:0];
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int r, input int c);
        pressed[4'(r*4+c)] = 1'b1;
    endtask

    task automatic unpress(input int r, input int c);
        pressed[4'(r*4+c)] = 1'b0;
    endtask

    // Monitor: every key_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!reset && key_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_pulse: key=%h with no pulse expected at %0t", key, $time);
            end else begin
                e = exp_q.pop_front();
                if (key !== e || key_held !== 1'b1) begin
                    miscompares++;
                    $display("FAIL pulse_key: key=%h held=%b, expected key=%h held=1 at %0t",
                             key, key_held, e, $time);
                end
            end
        end
    end

    initial begin
        logic [3:0] e;
        logic [3:0] prev;
        bit         found;
        int         r1, c1, r2, c2, t, n;

        // Reset values, then idle scan order and per-column dwell.
        step(3);
        check("rst_cols", cols, 4'b1110);
        check("rst_key", key, 4'h0);
        check("rst_valid", {3'b0, key_valid}, 4'h0);
        check("rst_held", {3'b0, key_held}, 4'h0);
        reset = 1'b0;
        for (int k = 1; k < 40; k++) begin
            step(1);
            e = 4'b0001 << ((k / SD) % 4);
            e = ~e;
            check("idle_cols", cols, e);
        end

        // One-tick glitch on row0 under column 0: no pulse, column not advanced.
        found = 1'b0;
        for (int i = 0; i < 8 * SD && !found; i++) begin
            prev = cols;
            step(1);
            if (cols == 4'b1110 && prev != 4'b1110) found = 1'b1;
        end
        check("glitch_sync", {3'b0, found}, 4'h1);
        press(0, 0);
        step(SD);
        unpress(0, 0);
        step(SD + 1);
        check("glitch_cols", cols, 4'b1110);
        step(GAP);

        // Key '6' held 100 cycles.
        press(1, 2);
        exp_q.push_back(4'h6);
        step(100);
        check("k6_held", {3'b0, key_held}, 4'h1);
        check("k6_key", key, 4'h6);
        unpress(1, 2);
        step(1);
        check("k6_held_rel", {3'b0, key_held}, 4'h1);
        step(GAP);
        check("k6_released", {3'b0, key_held}, 4'h0);
        check("k6_retain", key, 4'h6);

        // 'D' with a two-tick release bounce, then '0'.
        press(3, 3);
        exp_q.push_back(4'hD);
        step(LONG);
        unpress(3, 3);
        for (int i = 0; i < 2 * SD; i++) begin
            step(1);
            check("d_bounce_held", {3'b0, key_held}, 4'h1);
        end
        press(3, 3);
        for (int i = 0; i < LONG; i++) begin
            step(1);
            check("d_repress_held", {3'b0, key_held}, 4'h1);
        end
        unpress(3, 3);
        step(GAP);
        check("d_released", {3'b0, key_held}, 4'h0);
        press(3, 1);
        exp_q.push_back(4'h0);
        step(LONG);
        check("k0_key", key, 4'h0);
        unpress(3, 1);
        step(GAP);

        // '5' held, '9' pressed meanwhile; '9' reported only after '5' releases.
        press(1, 1);
        exp_q.push_back(4'h5);
        step(LONG);
        press(2, 2);
        step(20);
        check("k5_not9", key, 4'h5);
        unpress(1, 1);
        exp_q.push_back(4'h9);
        step(90);
        check("k9_key", key, 4'h9);
        unpress(2, 2);
        step(GAP);

        // Reset while '1' is held: state cleared, then a fresh confirmed pulse.
        press(0, 0);
        exp_q.push_back(4'h1);
        step(LONG);
        reset = 1'b1;
        step(1);
        check("rst1_cols", cols, 4'b1110);
        check("rst1_key", key, 4'h0);
        check("rst1_held", {3'b0, key_held}, 4'h0);
        reset = 1'b0;
        exp_q.push_back(4'h1);
        step(LONG);
        check("rst1_redetect", key, 4'h1);
        unpress(0, 0);
        step(GAP);

        // Randomized trials; each starts and ends with the keypad idle.
        for (int trial = 0; trial < 30; trial++) begin
            t  = $urandom_range(0, 4);
            r1 = $urandom_range(0, 3);
            c1 = $urandom_range(0, 3);
            n  = LONG + $urandom_range(0, 20);
            case (t)
                0: begin
                    press(r1, c1);
                    exp_q.push_back(key_of(r1, c1));
                    step(n);
                    check("rnd_key", key, key_of(r1, c1));
                    unpress(r1, c1);
                end
                1: begin
                    press(r1, c1);
                    step($urandom_range(1, DT * SD));
                    unpress(r1, c1);
                end
                2: begin
                    press(r1, c1);
                    exp_q.push_back(key_of(r1, c1));
                    step(n);
                    unpress(r1, c1);
                    step($urandom_range(1, (DT - 1) * SD));
                    check("rnd_bounce_held", {3'b0, key_held}, 4'h1);
                    press(r1, c1);
                    step(n);
                    unpress(r1, c1);
                end
                3: begin
                    r2 = $urandom_range(0, 3);
                    c2 = $urandom_range(0, 3);
                    if (r2 == r1 && c2 == c1) c2 = (c1 + 1) % 4;
                    press(r1, c1);
                    exp_q.push_back(key_of(r1, c1));
                    step(n);
                    press(r2, c2);
                    step($urandom_range(5, 20));
                    check("rnd_first_kept", key, key_of(r1, c1));
                    unpress(r1, c1);
                    exp_q.push_back(key_of(r2, c2));
                    step(90);
                    check("rnd_second_key", key, key_of(r2, c2));
                    unpress(r2, c2);
                end
                default: begin
                    r2 = (r1 + $urandom_range(1, 3)) % 4;
                    press(r1, c1);
                    press(r2, c1);
                    e = key_of((r1 < r2) ? r1 : r2, c1);
                    exp_q.push_back(e);
                    step(n);
                    check("rnd_lowest_row", key, e);
                    unpress(r1, c1);
                    unpress(r2, c1);
                end
            endcase
            step(GAP);
            check("rnd_idle_held", {3'b0, key_held}, 4'h0);
        end

        step(10);
        check("pending_pulses", 4'(exp_q.size()), 4'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
